// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer for the CPU device window.
// Word map (addr = byte address bits [3:2]):
//   0 CTRL   {28'b0, IM, MODE[1:0], EN}
//   1 PRESET reload value, read/write
//   2 COUNT  current count, read-only
//   3 reserved, reads 0, writes ignored
// Supports one-shot (MODE 00, also 10/11) and auto-reload (MODE 01) modes.
// irq is the stored expiry flag gated by CTRL.IM.
module timer_dev (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic        ctrl_wr;
    logic        preset_wr;
    logic        en;
    logic        im;
    logic        auto_reload;

    assign ctrl_wr     = we && (addr == ADDR_CTRL);
    assign preset_wr   = we && (addr == ADDR_PRESET);
    assign en          = ctrl[0];
    assign im          = ctrl[3];
    // Only MODE 01 reloads; the undefined encodings 10/11 act as one-shot.
    assign auto_reload = (ctrl[2:1] == 2'b01);

    assign irq = irq_flag & im;

    // Register state and countdown FSM; bus writes are applied last so they win conflicts.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the
            // pre-edge register values no matter the statement order.
            if (preset_wr) begin
                preset <= wd;
            end

            // In auto-reload mode the flag is a single-cycle pulse.
            if (irq_flag && auto_reload) begin
                irq_flag <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (en) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (count <= 32'd1) begin
                        // PRESET=0 lands here too: no wrap below zero.
                        count    <= 32'd0;
                        irq_flag <= 1'b1;
                        state    <= INT;
                    end else begin
                        count <= count - 32'd1;
                    end
                end
                INT: begin
                    if (!auto_reload) begin
                        ctrl[0] <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // NOTE: the last non-blocking assignment to a register in a block wins,
            // which is how a CTRL write overrides both the EN clear and the flag set.
            if (ctrl_wr) begin
                ctrl     <= wd[3:0];
                irq_flag <= 1'b0;
            end
        end
    end

    // Combinational read mux; zero-latency view of the registers.
    always_comb begin
        // NOTE: default assignment first so no path leaves rd unassigned (no latch).
        rd = 32'd0;
        case (addr)
            ADDR_CTRL:   rd = {28'd0, ctrl};
            ADDR_PRESET: rd = preset;
            ADDR_COUNT:  rd = count;
            default:     rd = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: self-checking bench for timer_dev.
// Each step drives one bus cycle, pushes the expected read/irq into a
// scoreboard queue, and pops/compares it just after the clock edge.
module tb_timer_dev;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    int checks = 0;
    int errors = 0;

    timer_dev dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wd    (wd),
        .rd    (rd),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  raddr;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic        we;
        logic [1:0]  waddr;
        logic [31:0] wd;
        logic [1:0]  raddr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus cycle: drive, clock, then read back raddr and compare against the scoreboard.
    task automatic step(input string name, input logic w, input logic [1:0] a, input logic [31:0] d,
                        input logic [1:0] raddr, input logic [31:0] exp_rd, input logic exp_irq);
        exp_t e;
        sb.push_back('{name, raddr, exp_rd, exp_irq});
        we   = w;
        addr = a;
        wd   = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        e = sb.pop_front();
        addr = e.raddr;
        #1;
        check({e.name, ".rd"}, rd, e.rd);
        check({e.name, ".irq"}, {31'd0, irq}, {31'd0, e.irq});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        wd    = 32'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Enable with PRESET=5 and follow COUNT/irq for four full periods of 8 cycles.
    task automatic run_periodic(input string tag, input logic [31:0] ctrl_val, input logic im);
        int p;
        logic [31:0] exp_cnt;
        logic        exp_irq;
        do_reset();
        step({tag, ".preset"}, 1'b1, 2'd1, 32'd5, 2'd1, 32'd5, 1'b0);
        step({tag, ".enable"}, 1'b1, 2'd0, ctrl_val, 2'd0, ctrl_val, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            p = (k - 2) % 8;
            exp_cnt = (k == 1) ? 32'd0 : ((p <= 5) ? 32'(5 - p) : 32'd0);
            exp_irq = im && (k >= 2) && (p == 5);
            step($sformatf("%s.k%0d", tag, k), 1'b0, 2'd0, 32'd0, 2'd2, exp_cnt, exp_irq);
        end
        step({tag, ".ctrl_kept"}, 1'b0, 2'd0, 32'd0, 2'd0, ctrl_val, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        wd    = 32'd0;

        // One-shot PRESET=5 walk plus ignored COUNT/reserved writes.
        vecs[0]  = '{1'b1, 2'd1, 32'd5,          2'd1, 32'd5, 1'b0};
        vecs[1]  = '{1'b1, 2'd0, 32'h9,          2'd0, 32'h9, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 32'd0,          2'd2, 32'd0, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 32'd0,          2'd2, 32'd5, 1'b0};
        vecs[4]  = '{1'b0, 2'd0, 32'd0,          2'd2, 32'd4, 1'b0};
        vecs[5]  = '{1'b0, 2'd0, 32'd0,          2'd2, 32'd3, 1'b0};
        vecs[6]  = '{1'b0, 2'd0, 32'd0,          2'd2, 32'd2, 1'b0};
        vecs[7]  = '{1'b0, 2'd0, 32'd0,          2'd2, 32'd1, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 32'd0,          2'd2, 32'd0, 1'b1};
        vecs[9]  = '{1'b0, 2'd0, 32'd0,          2'd0, 32'h8, 1'b1};
        vecs[10] = '{1'b0, 2'd0, 32'd0,          2'd0, 32'h8, 1'b1};
        vecs[11] = '{1'b0, 2'd0, 32'd0,          2'd2, 32'd0, 1'b1};
        vecs[12] = '{1'b1, 2'd0, 32'h8,          2'd0, 32'h8, 1'b0};
        vecs[13] = '{1'b0, 2'd0, 32'd0,          2'd2, 32'd0, 1'b0};
        vecs[14] = '{1'b1, 2'd2, 32'hFFFF_FFFF,  2'd2, 32'd0, 1'b0};
        vecs[15] = '{1'b1, 2'd3, 32'h0000_1234,  2'd3, 32'd0, 1'b0};
        vecs[16] = '{1'b0, 2'd0, 32'd0,          2'd1, 32'd5, 1'b0};

        // Reset state: all words read 0, irq low.
        do_reset();
        for (int a = 0; a < 4; a++) begin
            step($sformatf("reset.addr%0d", a), 1'b0, 2'd0, 32'd0, 2'(a), 32'd0, 1'b0);
        end

        // Table-driven one-shot sequence.
        for (int i = 0; i < 17; i++) begin
            step($sformatf("oneshot.v%0d", i), vecs[i].we, vecs[i].waddr, vecs[i].wd,
                 vecs[i].raddr, vecs[i].exp_rd, vecs[i].exp_irq);
        end

        // Auto-reload with and without the interrupt mask.
        run_periodic("auto_im", 32'hB, 1'b1);
        run_periodic("auto_noim", 32'h3, 1'b0);

        // Clear EN mid-count, then re-enable with a new PRESET.
        do_reset();
        step("dis.preset", 1'b1, 2'd1, 32'd5, 2'd1, 32'd5, 1'b0);
        step("dis.enable", 1'b1, 2'd0, 32'h9, 2'd2, 32'd0, 1'b0);
        step("dis.k1", 1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b0);
        step("dis.k2", 1'b0, 2'd0, 32'd0, 2'd2, 32'd5, 1'b0);
        step("dis.k3", 1'b0, 2'd0, 32'd0, 2'd2, 32'd4, 1'b0);
        step("dis.k4", 1'b0, 2'd0, 32'd0, 2'd2, 32'd3, 1'b0);
        step("dis.clear_en", 1'b1, 2'd0, 32'h8, 2'd2, 32'd2, 1'b0);
        step("dis.frozen1", 1'b0, 2'd0, 32'd0, 2'd2, 32'd2, 1'b0);
        step("dis.frozen2", 1'b0, 2'd0, 32'd0, 2'd2, 32'd2, 1'b0);
        step("dis.new_preset", 1'b1, 2'd1, 32'd2, 2'd2, 32'd2, 1'b0);
        step("dis.reenable", 1'b1, 2'd0, 32'h9, 2'd2, 32'd2, 1'b0);
        step("dis.r1", 1'b0, 2'd0, 32'd0, 2'd2, 32'd2, 1'b0);
        step("dis.r2", 1'b0, 2'd0, 32'd0, 2'd2, 32'd2, 1'b0);
        step("dis.r3", 1'b0, 2'd0, 32'd0, 2'd2, 32'd1, 1'b0);
        step("dis.r4", 1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b1);

        // PRESET=0 expires on the first CNT cycle, like PRESET=1.
        do_reset();
        step("zero.enable", 1'b1, 2'd0, 32'h9, 2'd2, 32'd0, 1'b0);
        step("zero.k1", 1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b0);
        step("zero.k2", 1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b0);
        step("zero.k3", 1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b1);
        step("zero.k4", 1'b0, 2'd0, 32'd0, 2'd0, 32'h8, 1'b1);

        // CTRL write on the edge that would set the flag: write wins, flag stays clear.
        do_reset();
        step("conf.preset", 1'b1, 2'd1, 32'd2, 2'd1, 32'd2, 1'b0);
        step("conf.enable", 1'b1, 2'd0, 32'h9, 2'd0, 32'h9, 1'b0);
        step("conf.k1", 1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b0);
        step("conf.k2", 1'b0, 2'd0, 32'd0, 2'd2, 32'd2, 1'b0);
        step("conf.k3", 1'b0, 2'd0, 32'd0, 2'd2, 32'd1, 1'b0);
        step("conf.k4_write", 1'b1, 2'd0, 32'h9, 2'd0, 32'h9, 1'b0);
        step("conf.k5", 1'b0, 2'd0, 32'd0, 2'd0, 32'h8, 1'b0);

        // Reset mid-count returns everything to zero.
        do_reset();
        step("rst.preset", 1'b1, 2'd1, 32'd5, 2'd1, 32'd5, 1'b0);
        step("rst.enable", 1'b1, 2'd0, 32'h9, 2'd2, 32'd0, 1'b0);
        step("rst.k1", 1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b0);
        step("rst.k2", 1'b0, 2'd0, 32'd0, 2'd2, 32'd5, 1'b0);
        step("rst.k3", 1'b0, 2'd0, 32'd0, 2'd2, 32'd4, 1'b0);
        step("rst.k4", 1'b0, 2'd0, 32'd0, 2'd2, 32'd3, 1'b0);
        do_reset();
        for (int a = 0; a < 4; a++) begin
            step($sformatf("rst.after.addr%0d", a), 1'b0, 2'd0, 32'd0, 2'(a), 32'd0, 1'b0);
        end
        step("rst.count_write", 1'b1, 2'd2, 32'hFFFF_FFFF, 2'd2, 32'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped countdown timer that responds on the CPU's device bus window (byte addresses 0x00007F00–0x00007FFF). It receives the device write strobe, address and write data, and returns combinational read data to the memory-stage read-data select. It raises an interrupt request toward CP0 when a count expires. The block supports one-shot and auto-reload modes.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- addr  in  2  word select, byte-address bits [3:2]: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved
- we  in  1  device write enable (already gated to the 0x7Fxx window upstream)
- wd  in  32  write data
- rd  out  32  read data, combinational from addr
- irq  out  1  interrupt request = irq_flag & CTRL.IM

## Operation
- CTRL register stores bits [3:0] only:
  - bit0 EN
  - bits[2:1] MODE: 00 one-shot, 01 auto-reload; 10/11 behave as 00
  - bit3 IM (interrupt mask, 1 = enabled)
- Reads of CTRL return {28'b0, ctrl[3:0]}.
- PRESET: 32-bit, read/write.
- COUNT: 32-bit, read-only. Writes to COUNT and to addr 3 are ignored; addr 3 reads 0.
- FSM states, all transitions on clock edges:
  - IDLE: if EN=1 -> LOAD; else stay.
  - LOAD: count <= PRESET -> CNT.
  - CNT:
    - if EN=0 -> IDLE, count holds.
    - else if count <= 1: count <= 0, irq_flag <= 1 -> INT.
    - else count <= count-1.
  - INT:
    - MODE 00: clear EN -> IDLE.
    - MODE 01: EN unchanged -> IDLE, which reloads via LOAD.
- irq_flag:
  - MODE 00: held until any CTRL write or reset.
  - MODE 01: cleared on the edge after it is set, giving a one-cycle pulse.
- Write/FSM conflicts:
  - A CTRL write in the same cycle as INT clearing EN: the written value wins.
  - A CTRL write in the same cycle the flag is set: the flag is cleared (write wins).
  - A PRESET write during CNT does not disturb count; it is used at the next LOAD.
- Arithmetic: unsigned 32-bit. PRESET=0 behaves like PRESET=1 (expires on the first CNT cycle). There is no wrap-around below 0.

## Timing
- Reset values: ctrl=0, preset=0, count=0, state=IDLE, irq_flag=0. Therefore irq=0 and rd=0 for addr 0–3.
- Writes take effect at the edge where we=1. Reads reflect register state after the latest edge, with zero latency.
- Expiry latency, with EN written at edge E0 and PRESET=N≥1:
  - LOAD at E1.
  - count=N at E2.
  - count=0 and irq_flag=1 after edge E0+N+2.
  - INT→IDLE at E0+N+3.
- Auto-reload period is N+3 cycles between irq pulses.
- Clearing EN mid-count: state is IDLE after the next edge; count is frozen.
- Re-enabling reloads from PRESET; counting does not resume from the frozen count.
- Reset asserted mid-operation: all state returns to reset values at that edge. An irq pending in that cycle is lost.
- A write with we=1 and addr=COUNT changes nothing.

## Test plan
- Reset, then read addr 0/1/2/3 -> rd=0 for all; irq=0.
- Write PRESET=5, then CTRL=0x9 (EN, one-shot, IM) at edge E0 -> count reads 5 after E2 and 4,3,2,1 on the following edges. irq rises after E0+7 and stays high. CTRL reads 0x8 after E0+8. Writing CTRL=0x8 clears irq.
- PRESET=5, CTRL=0xB (auto-reload, IM) -> one-cycle irq pulses exactly 8 cycles apart for ≥3 periods; EN stays 1.
- Same as the previous case with CTRL=0x3 (IM=0) -> irq never asserts; COUNT still cycles 5..0.
- During CNT with count=3, write CTRL=0x8 (EN=0) -> count frozen at 2, state IDLE. Then write PRESET=2 and CTRL=0x9 -> count reloads to 2 and irq fires 4 cycles after the enable write.
- Assert reset while count=3 -> all reads 0 and irq=0 next cycle. A COUNT write of 0xFFFF_FFFF -> COUNT still reads 0.
